// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, IF/ID register, fault capture
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MAX_ADDR = 32'(IMEM_BYTES - 4);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state;
    logic [31:0] cand;
    logic        redirect;
    logic [1:0]  cause;

    assign pc_plus4 = pc_out + 32'd4;
    assign redirect = jump | branch_taken;

    always_comb begin
        cand  = pc_out;
        cause = 2'b00;
        if (jump)
            cand = jump_target;
        else if (branch_taken)
            cand = branch_target;
        else if (!stall)
            cand = pc_plus4;
        // misaligned takes precedence over out-of-range
        if (cand[1:0] != 2'b00)
            cause = 2'b01;
        else if (cand > MAX_ADDR)
            cause = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc_out      <= RESET_PC;
            if_id_pc    <= 32'd0;
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= 2'b00;
            fault_pc    <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (cause != 2'b00) begin
                        state       <= FAULT;
                        fetch_fault <= 1'b1;
                        fault_cause <= cause;
                        fault_pc    <= cand;
                        if_id_valid <= 1'b0;
                    end else if (redirect) begin
                        // wrong-path fetch is squashed; redirect wins over stall
                        pc_out      <= cand;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        pc_out      <= cand;
                        if_id_pc    <= pc_out;
                        if_id_instr <= instruction;
                        if_id_valid <= 1'b1;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                FAULT: begin
                    if_id_valid <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target, instruction;
    logic [31:0] pc_out, pc_plus4, if_id_pc, if_id_instr, fault_pc, fetch_count;
    logic        if_id_valid, fetch_fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [8];

    logic [31:0] m_pc, m_ipc, m_iinstr, m_fpc, m_cnt;
    logic        m_valid, m_fault;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    assign instruction = (pc_out < 32'd32) ? imem[pc_out[4:2]] : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .instruction(instruction),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault), .fault_cause(fault_cause),
        .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Behavioural model of one clock edge, evaluated from the rules on the current inputs.
    task automatic model_edge();
        logic [31:0] target;
        if (rst) begin
            m_pc = 0; m_ipc = 0; m_iinstr = 32'h13; m_valid = 0;
            m_fault = 0; m_cause = 0; m_fpc = 0; m_cnt = 0;
        end else if (!m_fault) begin
            target = jump ? jump_target : branch_taken ? branch_target
                   : stall ? m_pc : m_pc + 4;
            if (target % 4 != 0) begin
                m_fault = 1; m_cause = 2'b01; m_fpc = target; m_valid = 0;
            end else if (target > 28) begin
                m_fault = 1; m_cause = 2'b10; m_fpc = target; m_valid = 0;
            end else if (jump || branch_taken) begin
                m_pc = target; m_valid = 0;
            end else if (!stall) begin
                m_ipc = m_pc; m_iinstr = imem[m_pc / 4]; m_valid = 1;
                m_cnt = m_cnt + 1; m_pc = target;
            end
        end
    endtask

    task automatic compare_all();
        check("pc_out", pc_out, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 4);
        check("if_id_pc", if_id_pc, m_ipc);
        check("if_id_instr", if_id_instr, m_iinstr);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        check("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
        check("fault_pc", fault_pc, m_fpc);
        check("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
        rst = r; stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt;
        #1;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        imem[0] = 32'hFFD0_0093;
        for (int i = 1; i < 8; i++) imem[i] = $urandom;

        // reset and sequential fetch
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        check("first_instr", if_id_instr, 32'hFFD0_0093);
        check("first_count", fetch_count, 32'd1);
        idle(1);
        check("pc_at_8", pc_out, 32'd8);

        // stall holds everything
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("stall_ifid_pc", if_id_pc, 32'd4);
        idle(1);
        check("after_stall_pc", pc_out, 32'd12);

        // branch overrides stall and flushes
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 1, 32'h10, 0, 0);
        check("branch_pc", pc_out, 32'h10);
        idle(1);
        check("branch_ifid_pc", if_id_pc, 32'h10);

        // jump beats branch
        cyc(0, 0, 1, 32'h10, 1, 32'h1C);
        check("jump_prio", pc_out, 32'h1C);

        // misaligned jump faults; later inputs ignored; reset clears
        cyc(0, 0, 0, 0, 1, 32'h0A);
        check("mis_cause", {30'd0, fault_cause}, 32'd1);
        cyc(0, 0, 0, 0, 1, 32'h04);
        idle(2);
        cyc(1, 1, 1, 32'h8, 1, 32'hC);
        check("reset_from_fault", pc_out, 32'd0);

        // sequential run off the end of memory
        idle(7);
        check("pc_at_1c", pc_out, 32'h1C);
        idle(1);
        check("oor_fault_pc", fault_pc, 32'h20);
        cyc(1, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, s, b, j;
            logic [31:0] bt, jt;
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            b  = ($urandom_range(0, 99) < 15);
            j  = ($urandom_range(0, 99) < 8);
            bt = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 7) * 4);
            jt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4);
            cyc(r, s, b, bt, j, jt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
